// File: rtl/spectral_frame_sequencer_if.sv
// Frame handshake bundle between the post-FFT section, cart_to_polar and the scaler.
// The sequencer takes the master side; the surrounding datapath takes the slave side.
interface spectral_frame_sequencer_if;
    logic fft_done;
    logic fft_release;
    logic c2p_go;
    logic c2p_buf;
    logic c2p_done;
    logic scaler_go;
    logic scaler_buf;
    logic scaler_done;

    modport master (
        input  fft_done,
        input  c2p_done,
        input  scaler_done,
        output fft_release,
        output c2p_go,
        output c2p_buf,
        output scaler_go,
        output scaler_buf
    );

    modport slave (
        output fft_done,
        output c2p_done,
        output scaler_done,
        input  fft_release,
        input  c2p_go,
        input  c2p_buf,
        input  scaler_go,
        input  scaler_buf
    );
endinterface

// File: rtl/spectral_frame_sequencer.sv
// Ping-pong frame sequencer: cart_to_polar fills scaler buffer pairs 0/1 alternately,
// the scaler drains them in the same order; frames with no free slot are dropped.
module spectral_frame_sequencer #(
    parameter int DROP_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    spectral_frame_sequencer_if.master    sif,
    output logic [3:0]                    buf_state,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          busy
);

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        FILLING  = 2'b01,
        FULL     = 2'b10,
        DRAINING = 2'b11
    } pair_state_e;

    typedef enum logic {P_IDLE = 1'b0, P_RUN = 1'b1} prod_state_e;
    typedef enum logic {C_IDLE = 1'b0, C_RUN = 1'b1} cons_state_e;

    prod_state_e        p_state_q, p_state_d;
    cons_state_e        c_state_q, c_state_d;
    pair_state_e        pair_q [2];
    pair_state_e        pair_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               pending_q, pending_d;
    logic               c2p_done_q;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               c2p_go_q, c2p_go_d;
    logic               c2p_buf_q, c2p_buf_d;
    logic               fft_release_q, fft_release_d;
    logic               scaler_go_q, scaler_go_d;
    logic               scaler_buf_q, scaler_buf_d;
    logic               busy_q, busy_d;

    logic               p_start;
    logic               c2p_rise;

    assign p_start  = (p_state_q == P_IDLE) && (pending_q || sif.fft_done) &&
                      (pair_q[wr_ptr_q] == EMPTY);
    assign c2p_rise = sif.c2p_done && !c2p_done_q;

    // Next-state for both FSMs, pair ownership, pending frame and drop counter.
    always_comb begin
        p_state_d     = p_state_q;
        c_state_d     = c_state_q;
        pair_d[0]     = pair_q[0];
        pair_d[1]     = pair_q[1];
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pending_d     = pending_q;
        drop_d        = drop_q;
        c2p_go_d      = 1'b0;
        c2p_buf_d     = c2p_buf_q;
        fft_release_d = 1'b0;
        scaler_go_d   = 1'b0;
        scaler_buf_d  = scaler_buf_q;

        case (p_state_q)
            P_IDLE: begin
                if (p_start) begin
                    p_state_d        = P_RUN;
                    c2p_go_d         = 1'b1;
                    c2p_buf_d        = wr_ptr_q;
                    pair_d[wr_ptr_q] = FILLING;
                end else begin
                    p_state_d = P_IDLE;
                end
            end
            P_RUN: begin
                if (c2p_rise) begin
                    p_state_d        = P_IDLE;
                    pair_d[wr_ptr_q] = FULL;
                    wr_ptr_d         = ~wr_ptr_q;
                    fft_release_d    = 1'b1;
                end else begin
                    p_state_d = P_RUN;
                end
            end
            default: p_state_d = P_IDLE;
        endcase

        // Pairs touched by producer and consumer are always different, so both may apply.
        case (c_state_q)
            C_IDLE: begin
                if (pair_q[rd_ptr_q] == FULL) begin
                    c_state_d        = C_RUN;
                    scaler_go_d      = 1'b1;
                    scaler_buf_d     = rd_ptr_q;
                    pair_d[rd_ptr_q] = DRAINING;
                end else begin
                    c_state_d = C_IDLE;
                end
            end
            C_RUN: begin
                if (sif.scaler_done) begin
                    c_state_d        = C_IDLE;
                    pair_d[rd_ptr_q] = EMPTY;
                    rd_ptr_d         = ~rd_ptr_q;
                end else begin
                    c_state_d = C_RUN;
                end
            end
            default: c_state_d = C_IDLE;
        endcase

        if (p_start) begin
            pending_d = pending_q && sif.fft_done;
        end else if (sif.fft_done) begin
            pending_d = 1'b1;
            if (pending_q && (drop_q != {DROP_W{1'b1}})) begin
                drop_d = drop_q + DROP_W'(1);
            end else begin
                drop_d = drop_q;
            end
        end else begin
            pending_d = pending_q;
        end

        busy_d = pending_d || (p_state_d == P_RUN) ||
                 (pair_d[0] != EMPTY) || (pair_d[1] != EMPTY);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_state_q     <= P_IDLE;
            c_state_q     <= C_IDLE;
            pair_q[0]     <= EMPTY;
            pair_q[1]     <= EMPTY;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            pending_q     <= 1'b0;
            c2p_done_q    <= 1'b0;
            drop_q        <= {DROP_W{1'b0}};
            c2p_go_q      <= 1'b0;
            c2p_buf_q     <= 1'b0;
            fft_release_q <= 1'b0;
            scaler_go_q   <= 1'b0;
            scaler_buf_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            p_state_q     <= p_state_d;
            c_state_q     <= c_state_d;
            pair_q[0]     <= pair_d[0];
            pair_q[1]     <= pair_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pending_q     <= pending_d;
            c2p_done_q    <= sif.c2p_done;
            drop_q        <= drop_d;
            c2p_go_q      <= c2p_go_d;
            c2p_buf_q     <= c2p_buf_d;
            fft_release_q <= fft_release_d;
            scaler_go_q   <= scaler_go_d;
            scaler_buf_q  <= scaler_buf_d;
            busy_q        <= busy_d;
        end
    end

    assign sif.c2p_go      = c2p_go_q;
    assign sif.c2p_buf     = c2p_buf_q;
    assign sif.fft_release = fft_release_q;
    assign sif.scaler_go   = scaler_go_q;
    assign sif.scaler_buf  = scaler_buf_q;
    assign buf_state       = {pair_q[1], pair_q[0]};
    assign drop_count      = drop_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_spectral_frame_sequencer.sv
// Directed and randomized bench for spectral_frame_sequencer; a frame-count reference
// model predicts every output each cycle. A DROP_W=2 copy shares the stimulus.
module tb_spectral_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] buf_state, buf_state2;
    logic [7:0] drop_count;
    logic [1:0] drop_count2;
    logic       busy, busy2;

    always #5 clk = ~clk;

    spectral_frame_sequencer_if sif ();
    spectral_frame_sequencer_if sif2 ();

    assign sif2.fft_done    = sif.fft_done;
    assign sif2.c2p_done    = sif.c2p_done;
    assign sif2.scaler_done = sif.scaler_done;

    spectral_frame_sequencer #(.DROP_W(8)) u_dut (
        .clk(clk), .reset(reset), .sif(sif),
        .buf_state(buf_state), .drop_count(drop_count), .busy(busy)
    );

    spectral_frame_sequencer #(.DROP_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .sif(sif2),
        .buf_state(buf_state2), .drop_count(drop_count2), .busy(busy2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frames are numbered in arrival order; frame k lives in pair k%2.
    int m_ns, m_nf, m_ng, m_nd;  // frames started/finished by producer, started/done by scaler
    int m_drops;
    bit m_pend, m_cprev;
    bit e_go, e_rel, e_sgo;
    int prod_age, cons_age;
    int auto_c2p, auto_sc;      // 0 = off, else response latency in cycles
    int cycle_no;
    int c2p_log[$], sc_log[$], go_cycles[$], sd_cycles[$];
    logic rc;
    int gap, wait_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pair_state(input int p);
        int k;
        if (m_ns <= p) return 2'b00;
        k = (((m_ns - 1) % 2) == p) ? (m_ns - 1) : (m_ns - 2);
        if (m_nd > k) return 2'b00;
        else if (m_ng > k) return 2'b11;
        else if (m_nf > k) return 2'b10;
        else return 2'b01;
    endfunction

    task automatic cyc(input logic fd, input logic cd, input logic sd, input logic rs);
        logic cd_e, sd_e;
        bit st, fin, cst, cdn;
        int ed, eb;
        cd_e = cd;
        sd_e = sd;
        cdn  = 1'b0;
        if (auto_c2p > 0 && m_ns > m_nf && prod_age >= auto_c2p) cd_e = 1'b1;
        if (auto_sc > 0 && m_ng > m_nd && cons_age >= auto_sc) sd_e = 1'b1;
        sif.fft_done    = fd;
        sif.c2p_done    = cd_e;
        sif.scaler_done = sd_e;
        reset           = rs;
        @(posedge clk);
        if (rs) begin
            m_ns = 0; m_nf = 0; m_ng = 0; m_nd = 0; m_drops = 0;
            m_pend = 1'b0; m_cprev = 1'b0;
            e_go = 1'b0; e_rel = 1'b0; e_sgo = 1'b0;
            prod_age = 0; cons_age = 0;
        end else begin
            st  = (m_ns == m_nf) && (m_pend || fd) && (m_nd + 1 >= m_ns);
            fin = (m_ns > m_nf) && cd_e && !m_cprev;
            cst = (m_ng == m_nd) && (m_ng < m_nf);
            cdn = (m_ng > m_nd) && sd_e;
            if (fd && m_pend && !st) m_drops++;
            m_pend   = st ? (m_pend && fd) : (m_pend || fd);
            prod_age = st ? 0 : prod_age + 1;
            cons_age = cst ? 0 : cons_age + 1;
            m_ns += int'(st); m_nf += int'(fin); m_ng += int'(cst); m_nd += int'(cdn);
            m_cprev = cd_e;
            e_go = st; e_rel = fin; e_sgo = cst;
        end
        @(negedge clk);
        cycle_no++;
        if (cdn) sd_cycles.push_back(cycle_no);
        if (sif.c2p_go === 1'b1) begin
            c2p_log.push_back(int'(sif.c2p_buf));
            go_cycles.push_back(cycle_no);
        end
        if (sif.scaler_go === 1'b1) sc_log.push_back(int'(sif.scaler_buf));
        ed = (m_drops > 255) ? 255 : m_drops;
        eb = (m_pend || m_ns != m_nd) ? 1 : 0;
        chk("c2p_go", sif.c2p_go, e_go);
        chk("c2p_buf", sif.c2p_buf, (m_ns > 0) ? (m_ns - 1) % 2 : 0);
        chk("fft_release", sif.fft_release, e_rel);
        chk("scaler_go", sif.scaler_go, e_sgo);
        chk("scaler_buf", sif.scaler_buf, (m_ng > 0) ? (m_ng - 1) % 2 : 0);
        chk("buf_state", buf_state, {pair_state(1), pair_state(0)});
        chk("buf_state_w2", buf_state2, {pair_state(1), pair_state(0)});
        chk("drop_count", drop_count, ed);
        chk("drop_count_w2", drop_count2, (m_drops > 3) ? 3 : m_drops);
        chk("busy", busy, eb);
        chk("busy_w2", busy2, eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        auto_c2p = 0; auto_sc = 0; cycle_no = 0; rc = 1'b0;
        m_ns = 0; m_nf = 0; m_ng = 0; m_nd = 0; m_drops = 0;
        m_pend = 1'b0; m_cprev = 1'b0; prod_age = 0; cons_age = 0;

        // Reset state
        do_reset(3);
        chk("reset_buf_state", buf_state, 4'b0000);
        chk("reset_busy", busy, 1'b0);
        chk("reset_drop", drop_count, 8'd0);

        // Single frame with exact latencies
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sf_c2p_go", sif.c2p_go, 1'b1);
        chk("sf_c2p_buf", sif.c2p_buf, 1'b0);
        idle(18);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sf_release", sif.fft_release, 1'b1);
        chk("sf_full", buf_state, 4'b0010);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sf_scaler_go", sif.scaler_go, 1'b1);
        chk("sf_scaler_buf", sif.scaler_buf, 1'b0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sf_empty", buf_state, 4'b0000);
        chk("sf_not_busy", busy, 1'b0);

        // Ping-pong with a slow scaler
        do_reset(2);
        c2p_log.delete(); sc_log.delete(); go_cycles.delete(); sd_cycles.delete();
        auto_c2p = 10; auto_sc = 60;
        for (int f = 0; f < 4; f++) begin
            for (int w = 0; w < 400 && m_pend; w++) idle(1);
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        wait_cnt = 0;
        while (wait_cnt < 1000 && !(sc_log.size() == 4 && busy === 1'b0)) begin
            idle(1);
            wait_cnt++;
        end
        chk("pp_finished_in_time", (wait_cnt < 1000) ? 1 : 0, 1);
        chk("pp_c2p_count", c2p_log.size(), 4);
        chk("pp_scaler_count", sc_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("pp_c2p_buf_seq", (i < c2p_log.size()) ? c2p_log[i] : -1, i % 2);
            chk("pp_scaler_buf_seq", (i < sc_log.size()) ? sc_log[i] : -1, i % 2);
        end
        gap = (go_cycles.size() > 2 && sd_cycles.size() > 0) ? go_cycles[2] - sd_cycles[0] : -1;
        chk("pp_third_go_gap", gap, 1);

        // Overflow: scaler never completes
        do_reset(2);
        auto_c2p = 10; auto_sc = 0;
        for (int f = 0; f < 5; f++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            idle(29);
        end
        chk("ovf_drop_count", drop_count, 8'd2);
        chk("ovf_buf_state", buf_state, 4'b1011);
        chk("ovf_busy", busy, 1'b1);

        // Saturation of the narrow counter
        for (int f = 0; f < 4; f++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            idle(2);
        end
        chk("sat_w2", drop_count2, 2'd3);
        chk("sat_w8", drop_count, 8'd6);

        // Spurious completions while idle
        do_reset(2);
        auto_c2p = 0;
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("spur_buf_state", buf_state, 4'b0000);
        chk("spur_drop", drop_count, 8'd0);
        chk("spur_busy", busy, 1'b0);

        // Reset mid-frame with c2p_done held high
        do_reset(2);
        auto_c2p = 10;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("mid_buf_state", buf_state, 4'b0111);
        auto_c2p = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        chk("mid_reset_buf", buf_state, 4'b0000);
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_go", sif.c2p_go, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            chk("mid_no_full", buf_state, 4'b0000);
        end

        // Randomized traffic including spurious pulses and occasional resets
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 4) == 0) rc = ~rc;
            cyc((($urandom % 10) == 0), rc, (($urandom % 7) == 0), (($urandom % 700) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spectral_frame_sequencer.md
Name: spectral_frame_sequencer

Overview:
- Sequences frames through the post-FFT section: post-FFT buffers -> cart_to_polar -> ping-pong scaler magnitude/phase buffers (index 0/1) -> scaler.
- Starts cart_to_polar on each FFT frame and selects which scaler buffer pair it writes. Starts the scaler on the filled pair and tracks ownership of both pairs.
- Strict frame ordering; frames arriving with no free slot are dropped and counted.

Parameters:
- DROP_W, 8, width of saturating dropped-frame counter

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fft_done  in  1  one-cycle pulse: new frame ready in post-FFT buffers
- fft_release  out  1  one-cycle pulse: post-FFT buffers may be overwritten
- c2p_go  out  1  one-cycle pulse to cart_to_polar go_in
- c2p_buf  out  1  scaler buffer pair cart_to_polar writes (drives its cur_buf select); stable while producer busy
- c2p_done  in  1  cart_to_polar go_out; level signal, a rising edge marks completion
- scaler_go  out  1  one-cycle pulse starting scaler
- scaler_buf  out  1  buffer pair scaler reads; stable while consumer busy
- scaler_done  in  1  one-cycle pulse: scaler finished reading scaler_buf
- buf_state  out  4  [1:0] = pair 0 state, [3:2] = pair 1 state
- drop_count  out  DROP_W  frames dropped since reset, saturating
- busy  out  1  high when pending, producer running, or any pair not EMPTY

Behaviour:
- Buffer pair states: EMPTY=00, FILLING=01, FULL=10, DRAINING=11.
- Reset values: all outputs 0, both pairs EMPTY, wr_ptr=rd_ptr=0, pending=0, c2p_done_q=0. Both FSMs are idle.
- All outputs are registered. All FSM decisions use registered state; nothing is combinationally bypassed.
- pending:
  - Set by fft_done; cleared when the producer starts.
  - If fft_done arrives while pending=1 and the producer is not starting that cycle: drop_count += 1 (saturates at all-ones), pending stays 1.
- Producer FSM:
  - P_IDLE -> P_RUN when (pending or fft_done) and buf[wr_ptr]==EMPTY. On that edge: c2p_go=1 for one cycle, c2p_buf=wr_ptr, buf[wr_ptr]<=FILLING, pending<=0.
  - fft_done sampled at edge t with pair free: c2p_go is high in cycle t+1.
  - P_RUN: when c2p_done & !c2p_done_q, go to P_IDLE. On that edge: buf[wr_ptr]<=FULL, wr_ptr toggles, fft_release=1 for one cycle.
  - A c2p_done rising edge seen in P_IDLE is ignored.
- Consumer FSM:
  - C_IDLE -> C_RUN when buf[rd_ptr]==FULL. On that edge: scaler_go=1 for one cycle, scaler_buf=rd_ptr, buf[rd_ptr]<=DRAINING.
  - C_RUN: on scaler_done, go to C_IDLE. On that edge: buf[rd_ptr]<=EMPTY, rd_ptr toggles.
  - scaler_done seen in C_IDLE is ignored.
- Latencies:
  - c2p_done rise sampled at edge t -> buf FULL from t+1 -> scaler_go high in cycle t+2.
  - scaler_done sampled at t frees the pair from t+1; a waiting producer issues c2p_go in cycle t+2.
- Ordering: pairs are filled and drained strictly alternately (0,1,0,1...). Producer never writes a non-EMPTY pair; consumer never reads a non-FULL pair.
- Simultaneous events:
  - Producer completion and consumer completion on the same edge update different pairs; both apply.
  - fft_done together with producer start (pending already 1): the new frame becomes pending, not dropped.
- Full: both pairs FULL/DRAINING and pending=1 -> producer stalls. Further fft_done pulses are dropped and counted.
- Reset mid-operation: in-flight frames are abandoned and all state returns to reset values. A c2p_done still high after reset is ignored because the producer is idle.

Test Plan:
- Single frame: fft_done at t -> c2p_go in cycle t+1 with c2p_buf=0. c2p_done rise at t+20 -> fft_release at t+21, buf_state=4'b0010 at t+21, scaler_go at t+22 with scaler_buf=0. scaler_done -> buf_state=0, busy=0.
- Ping-pong: four frames with a slow scaler -> c2p_buf sequence 0,1,0,1 and scaler_buf sequence 0,1,0,1. The third c2p_go waits until 2 cycles after the first scaler_done.
- Overflow: scaler never done, 5 fft_done pulses spaced 30 cycles apart -> two frames fill pairs, third frame pending, last two dropped. drop_count=2, buf_state=4'b1011.
- Saturation: DROP_W=2, force 6 drops -> drop_count holds at 3.
- Spurious inputs: scaler_done while consumer idle and c2p_done rise while producer idle -> no state change, drop_count=0.
- Reset mid-frame: assert reset while buf_state=4'b0111 -> next cycle all outputs 0. A held-high c2p_done does not create FULL.
